// File: rtl/video_pattern_streamer_pkg.sv
// Shared types and helpers for the synthetic video pattern streamer.
package video_pkg;

  typedef enum logic [2:0] {
    PAT_SOLID = 3'd0,
    PAT_BARS  = 3'd1,
    PAT_GRAD  = 3'd2,
    PAT_CHECK = 3'd3,
    PAT_MBAR  = 3'd4
  } pat_mode_e;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  // Which channels are lit; the level applied to lit channels is chosen by the pattern.
  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } rgb_t;

  function automatic rgb_t rgb_from_idx(input logic [2:0] idx);
    rgb_t p;
    p.r = idx[2];
    p.g = idx[1];
    p.b = idx[0];
    return p;
  endfunction

  // First x belonging to colour bar idx: smallest x with x*8 >= idx*h_active.
  function automatic int bar_bound(input int h_active, input int idx);
    return (idx * h_active + 7) / 8;
  endfunction

endpackage

// File: rtl/video_pattern_gen.sv
// Combinational pixel colour for coordinate (x, y) under the selected pattern.
module video_pattern_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int BPC        = 8,
  parameter int CHECK_LOG2 = 5,
  parameter int BAR_W      = 32,
  localparam int XW = $clog2(H_ACTIVE),
  localparam int YW = $clog2(V_ACTIVE)
) (
  input  logic [XW-1:0]    x,
  input  logic [YW-1:0]    y,
  input  logic [2:0]       mode,
  input  logic [XW-1:0]    bar_pos,
  input  logic [BPC-1:0]   grad,
  output logic [3*BPC-1:0] data
);

  localparam logic [XW:0] H_EXT = (XW+1)'(H_ACTIVE);

  logic [2:0]     bar_idx;
  logic [XW:0]    bar_off;
  logic           chk_bit;
  logic [BPC-1:0] lvl;
  rgb_t           on;

  always_comb begin
    bar_idx = '0;
    for (int i = 1; i < 8; i++) begin
      if (32'(x) >= 32'(bar_bound(H_ACTIVE, i))) bar_idx = 3'(i);
    end
    // Distance from the bar's left edge, wrapping around the line.
    bar_off = (x >= bar_pos) ? ({1'b0, x} - {1'b0, bar_pos})
                             : ({1'b0, x} + H_EXT - {1'b0, bar_pos});
    chk_bit = 1'((32'(x) >> CHECK_LOG2) ^ (32'(y) >> CHECK_LOG2));
    lvl = '1;
    case (mode)
      PAT_SOLID: on = rgb_from_idx(3'd7);
      PAT_BARS:  on = rgb_from_idx(bar_idx);
      PAT_GRAD: begin
        on  = rgb_from_idx(3'd7);
        lvl = grad;
      end
      PAT_CHECK: on = rgb_from_idx({3{chk_bit}});
      PAT_MBAR:  on = rgb_from_idx({3{32'(bar_off) < 32'(BAR_W)}});
      default:   on = rgb_from_idx(3'd0);
    endcase
  end

  assign data = {on.r ? lvl : '0, on.g ? lvl : '0, on.b ? lvl : '0};

endmodule

// File: rtl/video_pattern_streamer.sv
// Frame-based valid/ready RGB test-pattern source with sop/eop markers.
// state  | meaning
// IDLE   | no frame in progress, waiting for enable
// STREAM | a frame is being presented, output register holds the pending pixel
module video_pattern_streamer
  import video_pkg::*;
#(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int BPC        = 8,
  parameter int CHECK_LOG2 = 5,
  parameter int BAR_W      = 32,
  parameter int BAR_STEP   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [2:0]       mode,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [3*BPC-1:0] out_data,
  output logic             out_sop,
  output logic             out_eop,
  output logic [15:0]      frame_count,
  output logic             busy
);

  localparam int XW = $clog2(H_ACTIVE);
  localparam int YW = $clog2(V_ACTIVE);
  localparam int FMAX = (1 << BPC) - 1;
  localparam logic [XW-1:0]  X_LAST   = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0]  Y_LAST   = YW'(V_ACTIVE - 1);
  localparam logic [BPC-1:0] GRAD_Q   = BPC'(FMAX / (H_ACTIVE - 1));
  localparam logic [XW:0]    GRAD_R   = (XW+1)'(FMAX % (H_ACTIVE - 1));
  localparam logic [XW:0]    GRAD_DIV = (XW+1)'(H_ACTIVE - 1);
  localparam logic [XW:0]    H_EXT    = (XW+1)'(H_ACTIVE);
  localparam logic [XW:0]    STEP     = (XW+1)'(BAR_STEP);

  state_e           state_q, state_d;
  logic [XW-1:0]    x_q, x_n;
  logic [YW-1:0]    y_q, y_n;
  logic [XW-1:0]    bar_q, bar_n, bar_eff;
  logic [XW:0]      bar_sum;
  logic [BPC-1:0]   grad_q, grad_n;
  logic [XW:0]      grad_r_q, grad_r_n, r_sum;
  logic [2:0]       mode_q, mode_sel;
  logic             valid_q, valid_d, sop_q, eop_q, eop_n;
  logic [3*BPC-1:0] data_q, pix_n;
  logic [15:0]      fc_q;
  logic             xfer, load, start, frame_done;

  assign xfer = valid_q & out_ready;

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    load       = 1'b0;
    start      = 1'b0;
    frame_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          start   = 1'b1;
          load    = 1'b1;
          valid_d = 1'b1;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (xfer) begin
          load = 1'b1;
          if (eop_q) begin
            frame_done = 1'b1;
            if (enable) begin
              start = 1'b1;
            end else begin
              load    = 1'b0;
              valid_d = 1'b0;
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Gradient level is floor(x*FMAX/(H-1)) tracked as quotient plus remainder.
  always_comb begin
    x_n   = x_q + XW'(1);
    y_n   = y_q;
    r_sum = grad_r_q + GRAD_R;
    if (r_sum >= GRAD_DIV) begin
      grad_r_n = r_sum - GRAD_DIV;
      grad_n   = grad_q + GRAD_Q + BPC'(1);
    end else begin
      grad_r_n = r_sum;
      grad_n   = grad_q + GRAD_Q;
    end
    if (start) begin
      x_n      = '0;
      y_n      = '0;
      grad_n   = '0;
      grad_r_n = '0;
    end else if (x_q == X_LAST) begin
      x_n      = '0;
      y_n      = y_q + YW'(1);
      grad_n   = '0;
      grad_r_n = '0;
    end
  end

  assign bar_sum  = {1'b0, bar_q} + STEP;
  assign bar_n    = (bar_sum >= H_EXT) ? XW'(bar_sum - H_EXT) : XW'(bar_sum);
  assign bar_eff  = frame_done ? bar_n : bar_q;
  assign mode_sel = start ? mode : mode_q;
  assign eop_n    = (x_n == X_LAST) && (y_n == Y_LAST);

  video_pattern_gen #(
    .H_ACTIVE  (H_ACTIVE),
    .V_ACTIVE  (V_ACTIVE),
    .BPC       (BPC),
    .CHECK_LOG2(CHECK_LOG2),
    .BAR_W     (BAR_W)
  ) u_gen (
    .x      (x_n),
    .y      (y_n),
    .mode   (mode_sel),
    .bar_pos(bar_eff),
    .grad   (grad_n),
    .data   (pix_n)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      bar_q    <= '0;
      grad_q   <= '0;
      grad_r_q <= '0;
      mode_q   <= '0;
      valid_q  <= 1'b0;
      sop_q    <= 1'b0;
      eop_q    <= 1'b0;
      data_q   <= '0;
      fc_q     <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      if (start) mode_q <= mode;
      if (frame_done) begin
        fc_q  <= fc_q + 16'd1;
        bar_q <= bar_n;
      end
      if (load) begin
        x_q      <= x_n;
        y_q      <= y_n;
        grad_q   <= grad_n;
        grad_r_q <= grad_r_n;
        data_q   <= pix_n;
        sop_q    <= start;
        eop_q    <= eop_n;
      end else if (!valid_d) begin
        sop_q <= 1'b0;
        eop_q <= 1'b0;
      end
    end
  end

  assign out_valid   = valid_q;
  assign out_data    = data_q;
  assign out_sop     = sop_q;
  assign out_eop     = eop_q;
  assign frame_count = fc_q;
  assign busy        = (state_q == STREAM);

endmodule

// File: tb/tb_video_pattern_streamer.sv
// Scoreboard bench for video_pattern_streamer with a frame-level reference model.
module tb_video_pattern_streamer;

  localparam int H = 8, V = 4, BPC = 8, CL = 1, BW = 2, BS = 3;
  localparam int NPIX = H * V;

  logic        clk = 1'b0, rst_n = 1'b0, enable = 1'b0, out_ready = 1'b0;
  logic [2:0]  mode = 3'd0;
  logic        out_valid, out_sop, out_eop, busy;
  logic [23:0] out_data;
  logic [15:0] frame_count;

  video_pattern_streamer #(
    .H_ACTIVE(H), .V_ACTIVE(V), .BPC(BPC), .CHECK_LOG2(CL), .BAR_W(BW), .BAR_STEP(BS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop),
    .frame_count(frame_count), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] d;
    logic        sop;
    logic        eop;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          checks = 0, errors = 0;
  int          fidx = 0;
  int          ready_mode = 1;
  logic [15:0] exp_fc = 16'd0;
  logic        held = 1'b0;
  logic [25:0] held_v;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic logic [23:0] model_pix(input int m, input int x, input int y, input int bar);
    logic [2:0] ib;
    int v;
    case (m)
      0: return 24'hFFFFFF;
      1: begin
        ib = 3'((x * 8) / H);
        return {ib[2] ? 8'hFF : 8'h00, ib[1] ? 8'hFF : 8'h00, ib[0] ? 8'hFF : 8'h00};
      end
      2: begin
        v = (x * 255) / (H - 1);
        return {3{8'(v)}};
      end
      3: return ((((x >> CL) ^ (y >> CL)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
      4: return (((x - bar + H) % H) < BW) ? 24'hFFFFFF : 24'h000000;
      default: return 24'h000000;
    endcase
  endfunction

  task automatic push_frames(input int m, input int n);
    exp_t t;
    int bar;
    for (int f = 0; f < n; f++) begin
      bar = (fidx * BS) % H;
      fidx++;
      for (int y = 0; y < V; y++)
        for (int x = 0; x < H; x++) begin
          t.d   = model_pix(m, x, y, bar);
          t.sop = (x == 0 && y == 0);
          t.eop = (x == H - 1 && y == V - 1);
          sb.push_back(t);
        end
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: pops the scoreboard on every accepted pixel, checks hold stability.
  always @(negedge clk) begin
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      chk("frame_count", 64'(frame_count), 64'(exp_fc));
      if (held) chk("hold_stable", 64'({out_valid, out_sop, out_eop, out_data}), 64'({1'b1, held_v}));
      held = 1'b0;
      if (out_valid) begin
        if (out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_pixel: got data %0h with nothing expected", out_data);
          end else begin
            e = sb.pop_front();
            chk("pixel", 64'({out_sop, out_eop, out_data}), 64'({e.sop, e.eop, e.d}));
            if (e.eop) exp_fc = exp_fc + 16'd1;
          end
        end else begin
          held   = 1'b1;
          held_v = {out_sop, out_eop, out_data};
        end
      end
    end
  end

  task automatic wait_left(input int left, input string name);
    int n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (sb.size() > left && n < 2000);
    if (sb.size() > left) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout with %0d pixels outstanding, limit %0d", name, sb.size(), left);
    end
  endtask

  task automatic check_idle(input string name);
    chk({name, "_idle"}, 64'({busy, out_valid}), 64'(0));
  endtask

  task automatic run_frames(input int m, input int n, input int rm, input string name);
    ready_mode = rm;
    push_frames(m, n);
    mode   = 3'(m);
    enable = 1'b1;
    wait_left(NPIX - 2, name);
    enable = 1'b0;
    mode   = 3'($urandom_range(0, 7));
    wait_left(0, name);
    check_idle(name);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_outputs", {out_valid, out_sop, out_eop, busy, out_data, frame_count}, 64'(0));
    sb.delete();
    fidx   = 0;
    exp_fc = 16'd0;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    chk("reset_outputs", {out_valid, out_sop, out_eop, busy, out_data, frame_count}, 64'(0));
    release_reset();

    // Solid white, single frame, latency and busy drop.
    ready_mode = 1;
    push_frames(0, 1);
    @(posedge clk);
    #1;
    mode   = 3'd0;
    enable = 1'b1;
    chk("idle_valid", 64'(out_valid), 64'(0));
    @(posedge clk);
    #1;
    chk("first_valid_sop_busy", 64'({out_valid, out_sop, busy}), 64'(3'b111));
    enable = 1'b0;
    wait_left(0, "solid");
    check_idle("solid");

    run_frames(1, 2, 1, "bars");
    run_frames(2, 2, 2, "grad");

    do_reset();
    release_reset();
    run_frames(4, 4, 2, "mbar");
    run_frames(3, 1, 2, "check");
    run_frames(6, 1, 1, "black");

    // Mid-frame enable drop and mode change, then re-enable with the new mode.
    ready_mode = 2;
    push_frames(1, 1);
    mode   = 3'd1;
    enable = 1'b1;
    wait_left(NPIX - 5, "midframe");
    enable = 1'b0;
    mode   = 3'd3;
    wait_left(0, "midframe");
    check_idle("midframe");
    push_frames(3, 1);
    @(posedge clk);
    #1;
    enable = 1'b1;
    @(posedge clk);
    #1;
    chk("reenable_sop", 64'({out_valid, out_sop}), 64'(2'b11));
    enable = 1'b0;
    wait_left(0, "reenable");
    check_idle("reenable");

    // Reset with a pixel pending, restart from (0,0).
    ready_mode = 2;
    push_frames(0, 1);
    mode   = 3'd0;
    enable = 1'b1;
    wait_left(NPIX - 6, "rst_mid");
    ready_mode = 0;
    @(posedge clk);
    #2;
    chk("pending_valid", 64'(out_valid), 64'(1));
    mode = 3'd2;
    do_reset();
    ready_mode = 1;
    push_frames(2, 1);
    release_reset();
    wait_left(NPIX - 2, "rst_restart");
    enable = 1'b0;
    wait_left(0, "rst_restart");
    check_idle("rst_restart");
    chk("final_frame_count", 64'(frame_count), 64'(1));

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_pattern_streamer.md
Name: video_pattern_streamer

Overview:
- Parametrised synthetic video source; successor to the fixed artificial streamer. Generates full frames of RGB test patterns at any resolution and channel depth.
- Drives a valid/ready pixel stream with start/end-of-frame markers into the expander/VGA path.
- Adds mode-selectable patterns, backpressure handling, frame-boundary start/stop and an animated pattern.

Parameters:
- H_ACTIVE, 640, pixels per line (>=8, power of two not required).
- V_ACTIVE, 480, lines per frame (>=2).
- BPC, 8, bits per colour channel (1..10).
- CHECK_LOG2, 5, checkerboard tile edge = 2^CHECK_LOG2 pixels.
- BAR_W, 32, moving-bar width in pixels (1..H_ACTIVE).
- BAR_STEP, 4, moving-bar advance per frame in pixels (0..H_ACTIVE-1).

Ports:
- clk  in  1  pixel-domain clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  level; request streaming.
- mode  in  3  pattern select, sampled at frame start.
- out_ready  in  1  downstream accepts pixel.
- out_valid  out  1  pixel present.
- out_data  out  3*BPC  {R,G,B}, R in MSBs.
- out_sop  out  1  high with first pixel (x=0,y=0).
- out_eop  out  1  high with last pixel (x=H_ACTIVE-1,y=V_ACTIVE-1).
- frame_count  out  16  completed frames, wraps at 65535->0.
- busy  out  1  high while a frame is in progress.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_sop=0, out_eop=0, frame_count=0, busy=0, x=y=0, bar_pos=0, state IDLE.
- Transfer occurs on any rising edge with out_valid&&out_ready.
- FSM IDLE:
  - enable=1 -> latch mode into mode_q; load pixel (0,0) into the output register.
  - Next cycle: out_valid=1, out_sop=1, busy=1, state STREAM. Latency from enable sampled to first valid is 1 cycle.
- FSM STREAM:
  - On transfer, advance x. At x=H_ACTIVE-1, wrap x to 0 and increment y.
  - Next pixel registered in the same edge, so back-to-back transfers sustain 1 pixel/cycle.
  - Without transfer, out_data/out_sop/out_eop/out_valid hold stable; out_valid never drops while a pixel is pending.
- Transfer of the eop pixel:
  - frame_count+1; bar_pos=(bar_pos+BAR_STEP) mod H_ACTIVE.
  - If enable=1: relatch mode; present next frame's (0,0) with sop immediately (no gap).
  - Else: out_valid=0, busy=0, go to IDLE.
- enable deassert mid-frame has no effect until the frame ends; frames are never truncated.
- mode changes mid-frame are ignored until the next frame start.
- H_ACTIVE=1 edge is excluded by parameter range. sop and eop never coincide.
- Pattern for pixel (x,y), with F=2^BPC-1:
  - 0 solid white: all channels F.
  - 1 colour bars: idx=floor(x*8/H_ACTIVE), evaluated by comparison against elaboration-time boundaries. R=idx[2]?F:0, G=idx[1]?F:0, B=idx[0]?F:0.
  - 2 horizontal gradient: all channels = floor(x*F/(H_ACTIVE-1)), evaluated as an incremental accumulator stepped per transfer and reset at line start. No divider.
  - 3 checkerboard: white if x[CHECK_LOG2]^y[CHECK_LOG2], else black.
  - 4 moving bar: white if ((x - bar_pos) mod H_ACTIVE) < BAR_W, else black. bar_pos is constant within a frame.
  - 5..7: black.
- Counter widths: x = $clog2(H_ACTIVE), y = $clog2(V_ACTIVE), both unsigned. Arithmetic must not overflow at max parameter values.
- Reset asserted mid-frame: all outputs return to reset values immediately; the restart after release begins at (0,0) with sop.

Decomposition:
- Package video_pkg: pattern mode enum (PAT_SOLID, PAT_BARS, PAT_GRAD, PAT_CHECK, PAT_MBAR), state enum (IDLE, STREAM), rgb pixel struct generator function, bar-boundary constant function.
- Sub-module video_pattern_gen: combinational pixel colour from (x, y, mode_q, bar_pos, grad_acc). The streamer keeps the FSM, counters and output register.

Test Plan:
- Small config (H=8, V=4, BPC=8), mode 0, ready=1: 32 pixels 0xFFFFFF back-to-back; sop on pixel 0; eop on pixel 31; frame_count=1; busy drops 1 cycle after eop when enable=0.
- Mode 1, H=16: pixels x=0..15 give bars 000000,000000,0000FF,0000FF,00FF00,00FF00,00FFFF,00FFFF,FF0000,FF0000,FF00FF,FF00FF,FFFF00,FFFF00,FFFFFF,FFFFFF.
- Random out_ready (50%), mode 2, H=8: data stable while valid&&!ready. Accepted sequence per line is 00,24,48,6D,91,B6,DA,FF on each channel. No pixel lost or duplicated.
- Mode 4 with BAR_W=2, BAR_STEP=3, H=8: frame0 white at x=0,1; frame1 at x=3,4; frame2 at x=6,7; frame3 at x=1,2 (wrap).
- Deassert enable and change mode at pixel 5 of a frame: frame completes in its original mode, then IDLE. Re-enable: new mode is used, sop appears 1 cycle later.
- Assert rst_n=0 mid-frame with valid pending: outputs are 0 at once. After release with enable=1, the first pixel is (0,0) with sop and frame_count=0.
